// File: rtl/ecl_dev_pkg.sv
// Shared definitions for the device-region peripherals: register map,
// STATUS bit layout and serializer state encoding.
package ecl_dev_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;

  localparam int unsigned CTRL_IRQ_EN  = 0;
  localparam int unsigned CTRL_OVF_CLR = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/ecl_fifo_sync.sv
// Synchronous circular-buffer FIFO with extra-MSB pointers; a push while
// full is accepted when a pop happens in the same cycle.
module ecl_fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ecl_uart_dev.sv
// Memory-mapped 8N1 serial transmitter: bus register file, TX FIFO and
// serializer FSM.
module ecl_uart_dev
  import ecl_dev_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       _cs,
  input  logic       _oe,
  input  logic       _w,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       tx,
  output logic       irq
);

  localparam int unsigned       DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             wr_act;
  logic             wr_act_q;
  logic             wr_stb;
  logic             txdata_wr;
  logic             ctrl_wr;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             overflow_q;
  logic             irq_en_q;
  logic [7:0]       status;

  ser_state_e       state_q;
  ser_state_e       state_n;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_n;
  logic [2:0]       bit_q;
  logic [2:0]       bit_n;
  logic [7:0]       shift_q;
  logic [7:0]       shift_n;
  logic             tx_n;
  logic             div_last;

  // A held strobe writes once; only the rising edge of wr_act acts.
  assign wr_act    = ~_cs & ~_w;
  assign wr_stb    = wr_act & ~wr_act_q;
  assign txdata_wr = wr_stb && (addr == REG_TXDATA);
  assign ctrl_wr   = wr_stb && (addr == REG_CTRL);

  ecl_fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (txdata_wr),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_act_q   <= 1'b0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      if (txdata_wr && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end else if (ctrl_wr && data_in[CTRL_OVF_CLR]) begin
        overflow_q <= 1'b0;
      end
      if (ctrl_wr) irq_en_q <= data_in[CTRL_IRQ_EN];
      irq <= irq_en_q & (fifo_empty | overflow_q);
    end
  end

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = (state_q != IDLE);
    status[ST_FULL]      = fifo_full;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_OVF]       = overflow_q;
  end

  // Read path is side-effect free and only drives while read-selected.
  assign data_oe = ~_cs & ~_oe & _w;

  always_comb begin
    data_out = '0;
    if (data_oe) begin
      case (addr)
        REG_STATUS: data_out = status;
        REG_CTRL:   data_out = {7'b0, irq_en_q};
        default:    data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx      <= tx_n;
    end
  end

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_n  = state_q;
    div_n    = div_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    fifo_pop = 1'b0;
    tx_n     = 1'b1;

    case (state_q)
      IDLE: begin
        div_n = '0;
        bit_n = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_dout;
          state_n  = START;
        end
      end
      START: begin
        if (div_last) begin
          div_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (div_last) begin
          div_n   = '0;
          shift_n = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (div_last) begin
          div_n   = '0;
          state_n = IDLE;
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered so tx stays registered.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule
